// File: rtl/wb_stage_mc.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_mc
// Purpose  : Multi-channel write-back stage with program-order GPR conflict
//            resolution, HI/LO write-back and a serialising debug trace FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage_mc #(
  parameter int NCH         = 2,
  parameter int DATA_W      = 32,
  parameter int RADDR_W     = 5,
  parameter int TRACE_DEPTH = 8,
  parameter int STALL_W     = 6,
  parameter int STAGE_IDX   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
  input  logic [NCH-1:0]          mem_valid,
  input  logic [NCH*32-1:0]       mem_pc,
  input  logic [NCH-1:0]          mem_rf_we,
  input  logic [NCH*RADDR_W-1:0]  mem_rf_waddr,
  input  logic [NCH*DATA_W-1:0]   mem_rf_wdata,
  input  logic                    mem_hi_we,
  input  logic                    mem_lo_we,
  input  logic [DATA_W-1:0]       mem_hi,
  input  logic [DATA_W-1:0]       mem_lo,
  output logic [NCH-1:0]          rf_we,
  output logic [NCH*RADDR_W-1:0]  rf_waddr,
  output logic [NCH*DATA_W-1:0]   rf_wdata,
  output logic                    hi_we,
  output logic                    lo_we,
  output logic [DATA_W-1:0]       hi_o,
  output logic [DATA_W-1:0]       lo_o,
  output logic                    trace_stall_req,
  output logic                    trace_ovf,
  output logic [31:0]             retire_cnt,
  output logic [31:0]             debug_wb_pc,
  output logic [3:0]              debug_wb_rf_wen,
  output logic [4:0]              debug_wb_rf_wnum,
  output logic [31:0]             debug_wb_rf_wdata
);

  localparam int c_ptr_w = $clog2(TRACE_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(TRACE_DEPTH);
  localparam logic [c_cnt_w-1:0] c_nch   = c_cnt_w'(NCH);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  // Bundle register
  logic [NCH-1:0]          r_valid;
  logic [NCH*32-1:0]       r_pc;
  logic [NCH-1:0]          r_we;
  logic [NCH*RADDR_W-1:0]  r_waddr;
  logic [NCH*DATA_W-1:0]   r_wdata;
  logic                    r_hi_we;
  logic                    r_lo_we;
  logic [DATA_W-1:0]       r_hi;
  logic [DATA_W-1:0]       r_lo;
  logic                    r_fresh;

  // Trace FIFO
  logic [31:0]             r_mem_pc    [TRACE_DEPTH];
  logic [RADDR_W-1:0]      r_mem_waddr [TRACE_DEPTH];
  logic [DATA_W-1:0]       r_mem_wdata [TRACE_DEPTH];
  logic [c_ptr_w-1:0]      r_wr_ptr;
  logic [c_ptr_w-1:0]      r_rd_ptr;
  logic [c_cnt_w-1:0]      r_count;

  logic [NCH-1:0]          w_kill;
  logic [NCH-1:0]          w_enq;
  logic [c_ptr_w-1:0]      w_pos [NCH];
  logic [c_cnt_w-1:0]      w_n_enq;
  logic                    w_drop;
  logic                    w_deq;
  logic [c_cnt_w-1:0]      w_deq_ext;
  logic [c_cnt_w-1:0]      w_free;
  logic [31:0]             w_pop;
  logic                    w_unused_stall;

  assign w_unused_stall = ^stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_pc    <= '0;
      r_we    <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_hi_we <= 1'b0;
      r_lo_we <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_fresh <= 1'b0;
    end else if (stall[STAGE_IDX] && !stall[STAGE_IDX+1]) begin
      r_valid <= '0;
      r_we    <= '0;
      r_hi_we <= 1'b0;
      r_lo_we <= 1'b0;
      r_fresh <= 1'b0;
    end else if (!stall[STAGE_IDX]) begin
      r_valid <= mem_valid;
      r_pc    <= mem_pc;
      r_we    <= mem_rf_we;
      r_waddr <= mem_rf_waddr;
      r_wdata <= mem_rf_wdata;
      r_hi_we <= mem_hi_we;
      r_lo_we <= mem_lo_we;
      r_hi    <= mem_hi;
      r_lo    <= mem_lo;
      r_fresh <= 1'b1;
    end else begin
      r_fresh <= 1'b0;
    end
  end

  // An older slot is suppressed when any younger slot writes the same register
  always_comb begin
    w_kill = '0;
    for (int i = 0; i < NCH; i++) begin
      for (int j = i + 1; j < NCH; j++) begin
        if (r_valid[j] && r_we[j] &&
            r_waddr[j*RADDR_W +: RADDR_W] == r_waddr[i*RADDR_W +: RADDR_W])
          w_kill[i] = 1'b1;
      end
    end
  end

  assign rf_we    = r_valid & r_we & ~w_kill;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign hi_we    = r_hi_we & r_valid[0];
  assign lo_we    = r_lo_we & r_valid[0];
  assign hi_o     = r_hi;
  assign lo_o     = r_lo;

  assign w_deq           = (r_count != '0);
  assign w_deq_ext       = w_deq ? c_one : '0;
  assign w_free          = c_depth - r_count + w_deq_ext;
  assign trace_stall_req = (c_depth - r_count) < c_nch;

  // Slots are placed in channel order; once free space runs out the rest drop
  always_comb begin
    w_n_enq = '0;
    w_drop  = 1'b0;
    w_enq   = '0;
    w_pop   = '0;
    for (int i = 0; i < NCH; i++) begin
      w_pos[i] = '0;
      w_pop    = w_pop + 32'(r_valid[i]);
      if (r_fresh && r_valid[i] && r_we[i] &&
          r_waddr[i*RADDR_W +: RADDR_W] != '0) begin
        if (w_n_enq < w_free) begin
          w_enq[i] = 1'b1;
          w_pos[i] = w_n_enq[c_ptr_w-1:0];
          w_n_enq  = w_n_enq + c_one;
        end else begin
          w_drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (w_enq[i]) begin
        r_mem_pc[r_wr_ptr + w_pos[i]]    <= r_pc[i*32 +: 32];
        r_mem_waddr[r_wr_ptr + w_pos[i]] <= r_waddr[i*RADDR_W +: RADDR_W];
        r_mem_wdata[r_wr_ptr + w_pos[i]] <= r_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr          <= '0;
      r_rd_ptr          <= '0;
      r_count           <= '0;
      trace_ovf         <= 1'b0;
      retire_cnt        <= '0;
      debug_wb_pc       <= '0;
      debug_wb_rf_wen   <= '0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_n_enq[c_ptr_w-1:0];
      r_count  <= r_count + w_n_enq - w_deq_ext;
      if (w_drop)
        trace_ovf <= 1'b1;
      if (r_fresh)
        retire_cnt <= retire_cnt + w_pop;
      if (w_deq) begin
        r_rd_ptr          <= r_rd_ptr + 1'b1;
        debug_wb_pc       <= r_mem_pc[r_rd_ptr];
        debug_wb_rf_wen   <= 4'hF;
        debug_wb_rf_wnum  <= 5'(r_mem_waddr[r_rd_ptr]);
        debug_wb_rf_wdata <= 32'(r_mem_wdata[r_rd_ptr]);
      end else begin
        debug_wb_rf_wen   <= 4'h0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage_mc
// Purpose  : Directed self-checking bench for wb_stage_mc (NCH=2, depth 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [1:0]  mem_valid;
  logic [63:0] mem_pc;
  logic [1:0]  mem_rf_we;
  logic [9:0]  mem_rf_waddr;
  logic [63:0] mem_rf_wdata;
  logic        mem_hi_we, mem_lo_we;
  logic [31:0] mem_hi, mem_lo;
  logic [1:0]  rf_we;
  logic [9:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        hi_we, lo_we;
  logic [31:0] hi_o, lo_o;
  logic        trace_stall_req, trace_ovf;
  logic [31:0] retire_cnt;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_stage_mc dut (
    .clk(clk), .rst(rst), .stall(stall),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_rf_we(mem_rf_we),
    .mem_rf_waddr(mem_rf_waddr), .mem_rf_wdata(mem_rf_wdata),
    .mem_hi_we(mem_hi_we), .mem_lo_we(mem_lo_we), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .hi_we(hi_we), .lo_we(lo_we), .hi_o(hi_o), .lo_o(lo_o),
    .trace_stall_req(trace_stall_req), .trace_ovf(trace_ovf), .retire_cnt(retire_cnt),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  typedef struct {
    logic [1:0] v;
    logic [1:0] we;
    logic [4:0] a0;
    logic [4:0] a1;
    logic       hwe;
    logic       lwe;
    logic [3:0] e;   // {rf_we[1:0], hi_we, lo_we}
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setb(input logic [1:0] v, input logic [1:0] we,
                      input logic [4:0] a0, input logic [4:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic [31:0] pc0, input logic [31:0] pc1);
    mem_valid    = v;
    mem_rf_we    = we;
    mem_rf_waddr = {a1, a0};
    mem_rf_wdata = {d1, d0};
    mem_pc       = {pc1, pc0};
    mem_hi_we    = 1'b0;
    mem_lo_we    = 1'b0;
  endtask

  task automatic idle();
    setb(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_en"}, {58'h0, rf_we, hi_we, lo_we, trace_stall_req, trace_ovf}, 64'h0);
    chk({tag, "_retire"}, {32'h0, retire_cnt}, 64'h0);
    chk({tag, "_dbg"}, {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, 23'h0}, 64'h0);
    chk({tag, "_dbgdata"}, {32'h0, debug_wb_rf_wdata}, 64'h0);
    chk({tag, "_data"}, rf_wdata | {hi_o, lo_o}, 64'h0);
  endtask

  initial begin
    int n_seen;
    int n_deq;
    logic [31:0] prev_pc;

    tbl[0] = '{2'b11, 2'b11, 5'd3, 5'd4, 1'b0, 1'b0, 4'b1100};
    tbl[1] = '{2'b11, 2'b11, 5'd5, 5'd5, 1'b0, 1'b0, 4'b1000};
    tbl[2] = '{2'b01, 2'b11, 5'd5, 5'd5, 1'b0, 1'b0, 4'b0100};
    tbl[3] = '{2'b11, 2'b01, 5'd5, 5'd5, 1'b0, 1'b0, 4'b0100};
    tbl[4] = '{2'b10, 2'b11, 5'd5, 5'd5, 1'b0, 1'b0, 4'b1000};
    tbl[5] = '{2'b11, 2'b11, 5'd0, 5'd0, 1'b0, 1'b0, 4'b1000};
    tbl[6] = '{2'b11, 2'b00, 5'd6, 5'd6, 1'b1, 1'b1, 4'b0011};
    tbl[7] = '{2'b10, 2'b00, 5'd6, 5'd6, 1'b1, 1'b1, 4'b0000};
    tbl[8] = '{2'b01, 2'b10, 5'd9, 5'd9, 1'b1, 1'b0, 4'b0010};
    tbl[9] = '{2'b00, 2'b11, 5'd7, 5'd7, 1'b0, 1'b0, 4'b0000};

    rst = 1'b1;
    stall = '0;
    mem_hi = '0;
    mem_lo = '0;
    idle();
    step();
    step();
    chk_zero("reset_init");
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      setb(tbl[i].v, tbl[i].we, tbl[i].a0, tbl[i].a1,
           32'h100 + 32'(i), 32'h200 + 32'(i), 32'h0, 32'h4);
      mem_hi_we = tbl[i].hwe;
      mem_lo_we = tbl[i].lwe;
      mem_hi    = 32'hA000 + 32'(i);
      mem_lo    = 32'hB000 + 32'(i);
      step();
      chk($sformatf("tbl%0d_en", i), {60'h0, rf_we, hi_we, lo_we}, {60'h0, tbl[i].e});
      chk($sformatf("tbl%0d_data", i), rf_wdata, {32'h200 + 32'(i), 32'h100 + 32'(i)});
      chk($sformatf("tbl%0d_hilo", i), {hi_o, lo_o}, {32'hA000 + 32'(i), 32'hB000 + 32'(i)});
    end

    // Reset in the middle of traffic
    setb(2'b11, 2'b11, 5'd1, 5'd2, 32'h5, 32'h6, 32'h40, 32'h44);
    step();
    rst = 1'b1;
    step();
    step();
    chk_zero("reset_mid");
    rst = 1'b0;
    idle();
    mem_hi = '0;
    mem_lo = '0;

    // Single-slot retirement and trace latency
    setb(2'b01, 2'b01, 5'd8, 5'd0, 32'h1234, 32'h0, 32'hBFC00000, 32'h0);
    step();
    chk("single_rfwe", {62'h0, rf_we}, 64'h1);
    idle();
    step();
    chk("single_retire", {32'h0, retire_cnt}, 64'd1);
    chk("single_early_wen", {60'h0, debug_wb_rf_wen}, 64'h0);
    step();
    chk("single_trace", {debug_wb_pc, 23'h0, debug_wb_rf_wnum, debug_wb_rf_wen},
        {32'hBFC00000, 23'h0, 5'd8, 4'hF});
    chk("single_wdata", {32'h0, debug_wb_rf_wdata}, 64'h1234);

    // Same-address conflict: youngest wins, both traced
    setb(2'b11, 2'b11, 5'd5, 5'd5, 32'hA, 32'hB, 32'hBFC00004, 32'hBFC00008);
    step();
    chk("waw_rfwe", {62'h0, rf_we}, 64'h2);
    chk("waw_wdata1", {32'h0, rf_wdata[63:32]}, 64'hB);
    idle();
    step();
    step();
    chk("waw_trace0", {debug_wb_pc, debug_wb_rf_wdata}, {32'hBFC00004, 32'hA});
    chk("waw_wnum0", {59'h0, debug_wb_rf_wnum}, 64'd5);
    step();
    chk("waw_trace1", {debug_wb_pc, debug_wb_rf_wdata}, {32'hBFC00008, 32'hB});
    step();
    chk("waw_empty", {debug_wb_pc, 28'h0, debug_wb_rf_wen}, {32'hBFC00008, 32'h0});
    chk("waw_retire", {32'h0, retire_cnt}, 64'd3);

    // Hold: the held bundle stays visible but enqueues once
    setb(2'b11, 2'b11, 5'd1, 5'd2, 32'h11, 32'h22, 32'h200, 32'h204);
    step();
    chk("hold_capture", {62'h0, rf_we}, 64'h3);
    idle();
    stall = 6'b110000;
    n_seen = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("hold_rfwe%0d", k), {62'h0, rf_we}, 64'h3);
      if (debug_wb_rf_wen == 4'hF) n_seen++;
    end
    stall = 6'b000000;
    for (int k = 0; k < 3; k++) begin
      step();
      if (debug_wb_rf_wen == 4'hF) n_seen++;
    end
    chk("hold_entries", 64'(n_seen), 64'd2);
    chk("hold_retire", {32'h0, retire_cnt}, 64'd5);

    // Bubble, then hold the bubble
    setb(2'b11, 2'b11, 5'd3, 5'd4, 32'h33, 32'h44, 32'h300, 32'h304);
    stall = 6'b010000;
    step();
    chk("bubble_rfwe", {62'h0, rf_we}, 64'h0);
    stall = 6'b110000;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("bubble_hold%0d", k), {62'h0, rf_we}, 64'h0);
    end
    chk("bubble_retire", {32'h0, retire_cnt}, 64'd5);
    chk("bubble_wen", {60'h0, debug_wb_rf_wen}, 64'h0);
    stall = 6'b000000;
    idle();

    // HI/LO ownership by slot 0
    setb(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    mem_hi_we = 1'b1;
    mem_hi    = 32'hDEAD;
    step();
    chk("hi_invalid", {63'h0, hi_we}, 64'h0);
    setb(2'b01, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h500, 32'h0);
    mem_hi_we = 1'b1;
    step();
    chk("hi_valid", {31'h0, hi_we, hi_o}, {31'h0, 1'b1, 32'hDEAD});
    idle();
    for (int k = 0; k < 12; k++) step();
    chk("pre_ovf_ovf", {63'h0, trace_ovf}, 64'h0);

    // Back-to-back dual bundles ignoring stall request -> overflow
    n_deq = 0;
    prev_pc = '0;
    for (int k = 0; k < 25; k++) begin
      if (k < 10)
        setb(2'b11, 2'b11, 5'd1, 5'd2, 32'(k), 32'(k) + 32'h80,
             32'h1000 + 32'(8 * k), 32'h1004 + 32'(8 * k));
      else
        idle();
      step();
      if (debug_wb_rf_wen == 4'hF) begin
        n_deq++;
        chk($sformatf("ovf_order%0d", n_deq), 64'(debug_wb_pc > prev_pc), 64'h1);
        prev_pc = debug_wb_pc;
      end
      if (k <= 14)
        chk($sformatf("ovf_stallreq%0d", k), {63'h0, trace_stall_req},
            64'((k >= 6) && (k <= 11)));
      chk($sformatf("ovf_flag%0d", k), {63'h0, trace_ovf}, 64'(k >= 8));
    end
    chk("ovf_deq_total", 64'(n_deq), 64'd17);
    chk("ovf_retire", {32'h0, retire_cnt}, 64'd26);
    chk("ovf_drained", {60'h0, debug_wb_rf_wen}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
